// File: rtl/if_id_register.sv
// IF/ID pipeline register with load-use hazard detection, PCWrite/bubble generation and redirect flush.
// Optional stall/flush performance counters are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_register #(
  parameter logic [31:0] NOP_WORD = 32'hD503201F
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction_in,
  input  logic [63:0] PC_in,
  input  logic [63:0] PC_inc_in,
  input  logic        or_out,
  input  logic        Branchreg,
  input  logic        ext_stall,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_rd,
  output logic [31:0] instruction_out,
  output logic [63:0] PC_out,
  output logic [63:0] PC_inc_out,
  output logic        valid_out,
  output logic        PCWrite,
  output logic        bubble
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  logic [31:0] r_instr;
  logic [63:0] r_pc;
  logic [63:0] r_pc_inc;
  logic        r_valid;

  logic [4:0]  w_rn;
  logic [4:0]  w_rm;
  logic [4:0]  w_rt;
  logic        w_rd_match;
  logic        w_hazard;
  logic        w_stall;
  logic        w_flush;

  // Field compare ignores the opcode; immediates aliasing Rm/Rt may stall spuriously, which is harmless.
  assign w_rn       = r_instr[9:5];
  assign w_rm       = r_instr[20:16];
  assign w_rt       = r_instr[4:0];
  assign w_rd_match = (ID_EX_rd == w_rn) | (ID_EX_rd == w_rm) | (ID_EX_rd == w_rt);
  assign w_hazard   = r_valid & ID_EX_MemRead & (ID_EX_rd != 5'd31) & w_rd_match;
  assign w_stall    = w_hazard | ext_stall;
  assign w_flush    = or_out | Branchreg;

  assign PCWrite = ~w_stall | w_flush;
  assign bubble  = w_hazard | ~r_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_instr  <= NOP_WORD;
      r_pc     <= 64'd0;
      r_pc_inc <= 64'd0;
      r_valid  <= 1'b0;
    end else if (w_flush) begin
      r_instr  <= NOP_WORD;
      r_pc     <= PC_in;
      r_pc_inc <= PC_inc_in;
      r_valid  <= 1'b0;
    end else if (!w_stall) begin
      r_instr  <= instruction_in;
      r_pc     <= PC_in;
      r_pc_inc <= PC_inc_in;
      r_valid  <= 1'b1;
    end
  end

  assign instruction_out = r_instr;
  assign PC_out          = r_pc;
  assign PC_inc_out      = r_pc_inc;
  assign valid_out       = r_valid;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  // Counters saturate rather than wrap so long runs never alias back to small values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= 32'd0;
      r_flush_count <= 32'd0;
    end else begin
      if (w_stall && !w_flush && (r_stall_count != 32'hFFFF_FFFF))
        r_stall_count <= r_stall_count + 32'd1;
      if (w_flush && (r_flush_count != 32'hFFFF_FFFF))
        r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_if_id_register.sv
// Bench for if_id_register: directed vector table, a reference-model random run,
// and (with IF_ID_PERF_CNT_EN) counter checks.
module tb_if_id_register;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clock;
  logic        reset;
  logic [31:0] instruction_in;
  logic [63:0] PC_in;
  logic [63:0] PC_inc_in;
  logic        or_out;
  logic        Branchreg;
  logic        ext_stall;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_rd;
  logic [31:0] instruction_out;
  logic [63:0] PC_out;
  logic [63:0] PC_inc_out;
  logic        valid_out;
  logic        PCWrite;
  logic        bubble;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_count;
  logic [31:0] flush_count;
`endif

  if_id_register dut (
    .clock           (clock),
    .reset           (reset),
    .instruction_in  (instruction_in),
    .PC_in           (PC_in),
    .PC_inc_in       (PC_inc_in),
    .or_out          (or_out),
    .Branchreg       (Branchreg),
    .ext_stall       (ext_stall),
    .ID_EX_MemRead   (ID_EX_MemRead),
    .ID_EX_rd        (ID_EX_rd),
    .instruction_out (instruction_out),
    .PC_out          (PC_out),
    .PC_inc_out      (PC_inc_out),
    .valid_out       (valid_out),
    .PCWrite         (PCWrite),
    .bubble          (bubble)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_count     (stall_count),
    .flush_count     (flush_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic [63:0] pc;
    logic        orr, br, es, mr;
    logic [4:0]  rd;
    logic        e_pcw, e_bub;
    logic [31:0] e_ins;
    logic [63:0] e_pc, e_inc;
    logic        e_val;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [31:0] ins, input logic [63:0] pc,
                              input logic orr, input logic br, input logic es, input logic mr,
                              input logic [4:0] rd, input logic e_pcw, input logic e_bub,
                              input logic [31:0] e_ins, input logic [63:0] e_pc, input logic e_val);
    vec_t v;
    v.rst = rst; v.ins = ins; v.pc = pc; v.orr = orr; v.br = br; v.es = es; v.mr = mr; v.rd = rd;
    v.e_pcw = e_pcw; v.e_bub = e_bub; v.e_ins = e_ins; v.e_pc = e_pc; v.e_val = e_val;
    v.e_inc = rst ? 64'd0 : e_pc + 64'd4;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic [31:0] ins, input logic [63:0] pc,
                       input logic orr, input logic br, input logic es, input logic mr,
                       input logic [4:0] rd);
    reset = rst; instruction_in = ins; PC_in = pc; PC_inc_in = pc + 64'd4;
    or_out = orr; Branchreg = br; ext_stall = es; ID_EX_MemRead = mr; ID_EX_rd = rd;
  endtask

  // Reference model state: what IF/ID should hold, derived from the redirect/stall rules.
  logic [31:0] m_ins;
  logic [63:0] m_pc, m_inc;
  logic        m_val;
  longint      m_sc, m_fc;

  function automatic logic model_hazard(input logic mr, input logic [4:0] rd);
    logic [4:0] f [3];
    f[0] = m_ins[9:5]; f[1] = m_ins[20:16]; f[2] = m_ins[4:0];
    if (!m_val || !mr || rd == 5'd31) return 1'b0;
    foreach (f[k]) if (f[k] == rd) return 1'b1;
    return 1'b0;
  endfunction

  vec_t tbl[14];

  initial begin
    logic hz, st, fl;
    logic [4:0] rd;
    logic [4:0] flds [3];

    drive(1'b1, 32'h0, 64'h0, 0, 0, 0, 0, 5'd0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_instr", instruction_out, NOP);
    check("reset_pc", PC_out, 64'd0);
    check("reset_pcinc", PC_inc_out, 64'd0);
    check("reset_valid", valid_out, 1'b0);
    check("reset_pcwrite", PCWrite, 1'b1);
    check("reset_bubble", bubble, 1'b1);

    tbl[0]  = mk(0, 32'hF84003E1, 64'h40,  0, 0, 0, 0, 5'd0,  1, 1, 32'hF84003E1, 64'h40,  1);
    tbl[1]  = mk(0, 32'h8B030022, 64'h44,  0, 0, 0, 0, 5'd0,  1, 0, 32'h8B030022, 64'h44,  1);
    tbl[2]  = mk(0, 32'h8B0303E2, 64'h48,  0, 0, 0, 1, 5'd1,  0, 1, 32'h8B030022, 64'h44,  1);
    tbl[3]  = mk(0, 32'h8B0303E2, 64'h48,  0, 0, 0, 0, 5'd0,  1, 0, 32'h8B0303E2, 64'h48,  1);
    tbl[4]  = mk(0, 32'h8B040062, 64'h4C,  0, 0, 0, 1, 5'd31, 1, 0, 32'h8B040062, 64'h4C,  1);
    tbl[5]  = mk(0, 32'h12345678, 64'h100, 1, 0, 0, 1, 5'd3,  1, 1, NOP,          64'h100, 0);
    tbl[6]  = mk(0, 32'h8B040062, 64'h104, 0, 0, 0, 0, 5'd0,  1, 1, 32'h8B040062, 64'h104, 1);
    tbl[7]  = mk(0, 32'h11111111, 64'h200, 0, 0, 1, 0, 5'd0,  0, 0, 32'h8B040062, 64'h104, 1);
    tbl[8]  = mk(0, 32'h11111111, 64'h200, 0, 0, 1, 0, 5'd0,  0, 0, 32'h8B040062, 64'h104, 1);
    tbl[9]  = mk(0, 32'h11111111, 64'h200, 0, 0, 1, 0, 5'd0,  0, 0, 32'h8B040062, 64'h104, 1);
    tbl[10] = mk(0, 32'h11111111, 64'h200, 0, 0, 0, 0, 5'd0,  1, 0, 32'h11111111, 64'h200, 1);
    tbl[11] = mk(1, 32'h22222222, 64'h300, 0, 0, 0, 1, 5'd17, 0, 1, NOP,          64'h0,   0);
    tbl[12] = mk(0, 32'h22222222, 64'h300, 0, 0, 0, 1, 5'd17, 1, 1, 32'h22222222, 64'h300, 1);
    tbl[13] = mk(0, 32'h33333333, 64'h400, 0, 1, 0, 0, 5'd0,  1, 0, NOP,          64'h400, 0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].ins, tbl[i].pc, tbl[i].orr, tbl[i].br, tbl[i].es, tbl[i].mr, tbl[i].rd);
      #4;
      check($sformatf("vec%0d_pcwrite", i), PCWrite, tbl[i].e_pcw);
      check($sformatf("vec%0d_bubble", i), bubble, tbl[i].e_bub);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_instr", i), instruction_out, tbl[i].e_ins);
      check($sformatf("vec%0d_pc", i), PC_out, tbl[i].e_pc);
      check($sformatf("vec%0d_pcinc", i), PC_inc_out, tbl[i].e_inc);
      check($sformatf("vec%0d_valid", i), valid_out, tbl[i].e_val);
    end

    // Random run against the model, starting from a fresh reset.
    drive(1'b1, 32'h0, 64'h0, 0, 0, 0, 0, 5'd0);
    @(posedge clock);
    #1;
    m_ins = NOP; m_pc = 0; m_inc = 0; m_val = 0; m_sc = 0; m_fc = 0;
    for (int c = 0; c < 400; c++) begin
      flds[0] = m_ins[9:5]; flds[1] = m_ins[20:16]; flds[2] = m_ins[4:0];
      rd = ($urandom_range(0, 2) != 0) ? flds[$urandom_range(0, 2)] : 5'($urandom);
      drive($urandom_range(0, 31) == 0, $urandom, {32'h0, $urandom & 32'hFFFF_FFFC},
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, rd);
      hz = model_hazard(ID_EX_MemRead, ID_EX_rd);
      st = hz || ext_stall;
      fl = or_out || Branchreg;
      #4;
      check("rand_pcwrite", PCWrite, !st || fl);
      check("rand_bubble", bubble, hz || !m_val);
      @(posedge clock);
      if (reset) begin
        m_ins = NOP; m_pc = 0; m_inc = 0; m_val = 0; m_sc = 0; m_fc = 0;
      end else begin
        if (fl) begin
          m_ins = NOP; m_pc = PC_in; m_inc = PC_inc_in; m_val = 0;
          m_fc = (m_fc < 64'hFFFF_FFFF) ? m_fc + 1 : m_fc;
        end else if (st) begin
          m_sc = (m_sc < 64'hFFFF_FFFF) ? m_sc + 1 : m_sc;
        end else begin
          m_ins = instruction_in; m_pc = PC_in; m_inc = PC_inc_in; m_val = 1;
        end
      end
      #1;
      check("rand_instr", instruction_out, m_ins);
      check("rand_pc", PC_out, m_pc);
      check("rand_pcinc", PC_inc_out, m_inc);
      check("rand_valid", valid_out, m_val);
`ifdef IF_ID_PERF_CNT_EN
      check("rand_stall_count", stall_count, m_sc[31:0]);
      check("rand_flush_count", flush_count, m_fc[31:0]);
`endif
    end

`ifdef IF_ID_PERF_CNT_EN
    // Two load-use stalls and one register-indirect flush.
    drive(1'b1, 32'h0, 64'h0, 0, 0, 0, 0, 5'd0);
    @(posedge clock); #1;
    drive(0, 32'h8B030022, 64'h40, 0, 0, 0, 0, 5'd0); @(posedge clock); #1;
    drive(0, 32'h8B030022, 64'h44, 0, 0, 0, 1, 5'd1); @(posedge clock); #1;
    drive(0, 32'h8B030022, 64'h44, 0, 0, 0, 0, 5'd0); @(posedge clock); #1;
    drive(0, 32'h8B030022, 64'h48, 0, 0, 0, 1, 5'd1); @(posedge clock); #1;
    drive(0, 32'h8B030022, 64'h48, 0, 0, 0, 0, 5'd0); @(posedge clock); #1;
    drive(0, 32'h8B030022, 64'h4C, 0, 1, 0, 0, 5'd0); @(posedge clock); #1;
    check("perf_stall_count", stall_count, 32'd2);
    check("perf_flush_count", flush_count, 32'd1);
    force dut.r_stall_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_count;
    drive(0, 32'h0, 64'h50, 0, 0, 1, 0, 5'd0); @(posedge clock); #1;
    check("perf_stall_saturate", stall_count, 32'hFFFF_FFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/if_id_register.md
# if_id_register

IF/ID pipeline register with integrated load-use hazard detection for the pipelined ARMv8 core. It captures the fetched instruction, its PC and PC+4 from the fetch stage and presents them to decode. It generates `PCWrite` back to fetch and a `bubble` select to zero the control word entering ID/EX. On a redirect it flushes the captured instruction to a NOP.

## Interface
Parameters:
- `NOP_WORD`, `32'hD503201F`: ARMv8 NOP encoding inserted on flush and reset.

Ports:
- `clock`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high.
- `instruction_in`  input  32  fetched instruction word from the fetch stage.
- `PC_in`  input  64  PC of the fetched instruction.
- `PC_inc_in`  input  64  PC+4 of the fetched instruction (branch-link value).
- `or_out`  input  1  conditional/unconditional branch taken; redirects fetch.
- `Branchreg`  input  1  register-indirect branch (BR) taken; redirects fetch.
- `ext_stall`  input  1  external hold, e.g. memory not ready.
- `ID_EX_MemRead`  input  1  instruction currently in ID/EX is a load.
- `ID_EX_rd`  input  5  destination register of the ID/EX instruction.
- `instruction_out`  output  32  registered instruction to decode.
- `PC_out`  output  64  registered PC.
- `PC_inc_out`  output  64  registered PC+4.
- `valid_out`  output  1  registered instruction is real (not bubble/flush).
- `PCWrite`  output  1  1 = fetch advances PC; 0 = fetch holds PC.
- `bubble`  output  1  1 = ID/EX control mux selects all-zero control.
- `stall_count`  output  32  only with `IF_ID_PERF_CNT_EN`.
- `flush_count`  output  32  only with `IF_ID_PERF_CNT_EN`.

## Operation
- Field extraction from `instruction_out`: Rn = [9:5], Rm = [20:16], Rt = [4:0].
- `hazard` = `valid_out` & `ID_EX_MemRead` & (`ID_EX_rd` != 31) & (`ID_EX_rd` equals Rn, Rm or Rt).
- The comparison is conservative: immediate bits aliasing Rm/Rt may cause false stalls. This is accepted and is not a bug.
- `stall` = `hazard` | `ext_stall`.
- `flush` = `or_out` | `Branchreg`.
- Combinational outputs:
  - `PCWrite` = ~`stall` | `flush`.
  - `bubble` = `hazard` | ~`valid_out`.
- Register update, priority highest first:
  1. `reset`: `instruction_out`=`NOP_WORD`, `PC_out`=0, `PC_inc_out`=0, `valid_out`=0.
  2. `flush`: `instruction_out`=`NOP_WORD`, `valid_out`=0; PC fields load `PC_in`/`PC_inc_in` (don't-care but defined).
  3. `stall`: all registers hold.
  4. Otherwise: load `instruction_in`, `PC_in`, `PC_inc_in`; `valid_out`=1.
- Flush overrides stall. A redirect during a load-use stall discards the held instruction, and fetch advances to the target.

## Timing
- Latency: an instruction presented in cycle N appears on the outputs in cycle N+1 unless stalled or flushed.
- Load-use stall lasts exactly one cycle:
  - Cycle N: `hazard`=1, `PCWrite`=0, `bubble`=1, IF/ID holds.
  - Cycle N+1: the bubble is in ID/EX, so its MemRead=0 and `hazard` drops.
- `ext_stall` holds for as many cycles as it is asserted. `bubble` is not raised by `ext_stall` alone.
- `hazard` and `PCWrite` are purely combinational from registered state and inputs, with no added cycle.
- During and after `reset`, `valid_out`=0, so `hazard`=0, `PCWrite`=1 and `bubble`=1.
- Reset asserted mid-stall clears the stall in the next cycle.

## Configuration
- Macro `IF_ID_PERF_CNT_EN`.
- When defined:
  - `stall_count` increments on each cycle with `stall` & ~`flush`.
  - `flush_count` increments on each cycle with `flush`.
  - Both counters saturate at `32'hFFFFFFFF` and reset to 0.
- When undefined: both ports and their counters are absent. The block has no other behavioural difference.

## Test plan
- Reset, then one clock with `instruction_in`=`32'hF84003E1` (LDUR X1,[SP]) and `PC_in`=0x40: `instruction_out`=`32'hF84003E1`, `PC_out`=0x40, `PC_inc_out`=0x44, `valid_out`=1.
- Load-use: IF/ID holds ADD X2,X1,X3, `ID_EX_MemRead`=1, `ID_EX_rd`=1:
  - That cycle: `PCWrite`=0, `bubble`=1, outputs hold.
  - Next cycle, with `ID_EX_MemRead`=0: `PCWrite`=1, and the new instruction loads.
- `ID_EX_rd`=31 with `ID_EX_MemRead`=1 and a matching field: no stall, `PCWrite`=1.
- `or_out`=1 together with a load-use hazard: next cycle `instruction_out`=`32'hD503201F` and `valid_out`=0; `PCWrite`=1 in the flush cycle.
- `ext_stall` high for 3 cycles: outputs constant for 3 cycles, `bubble`=0, `PCWrite`=0; then resumes.
- With `IF_ID_PERF_CNT_EN`: 2 load-use stalls plus 1 `Branchreg` flush give `stall_count`=2 and `flush_count`=1; a preloaded counter at `32'hFFFFFFFF` stays there.
